// File: rtl/dct_pkg.sv
// Shared definitions for the DCT row sequencer.
// Holds the default geometry (samples per row, sample width, result width),
// the sequencer state enumeration and the Q5.10 representation of 1.0.
package dct_pkg;

    localparam int N_DEF  = 8;
    localparam int DW_DEF = 15;
    localparam int OW_DEF = 18;

    // 1.0 in Q5.10 two's complement.
    localparam logic [14:0] Q5_10_ONE = 15'h0400;

    typedef enum logic [2:0] {
        FILL  = 3'd0,
        CLR   = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        OUT   = 3'd4
    } state_t;

endpackage

// File: rtl/dct_row_sequencer_if.sv
// Bus bundle around the DCT row sequencer.
// Groups three links:
//   sample stream  : s_valid, s_ready, s_data            (source -> sequencer)
//   datapath drive : dp_clr, dp_en, dp_in, dp_o1..dp_o4  (sequencer <-> add_up)
//   result stream  : m_valid, m_ready, m_data0..m_data3  (sequencer -> sink)
// Modports:
//   master : the sequencer side
//   slave  : the environment (source, datapath and sink)
interface dct_row_sequencer_if
    import dct_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int OW = OW_DEF
);

    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;

    logic          dp_clr;
    logic          dp_en;
    logic [DW-1:0] dp_in;
    logic [OW-1:0] dp_o1;
    logic [OW-1:0] dp_o2;
    logic [OW-1:0] dp_o3;
    logic [OW-1:0] dp_o4;

    logic          m_valid;
    logic          m_ready;
    logic [OW-1:0] m_data0;
    logic [OW-1:0] m_data1;
    logic [OW-1:0] m_data2;
    logic [OW-1:0] m_data3;

    modport master (
        input  s_valid, s_data,
        output s_ready,
        output dp_clr, dp_en, dp_in,
        input  dp_o1, dp_o2, dp_o3, dp_o4,
        output m_valid, m_data0, m_data1, m_data2, m_data3,
        input  m_ready
    );

    modport slave (
        output s_valid, s_data,
        input  s_ready,
        input  dp_clr, dp_en, dp_in,
        output dp_o1, dp_o2, dp_o3, dp_o4,
        input  m_valid, m_data0, m_data1, m_data2, m_data3,
        output m_ready
    );

endinterface

// File: rtl/dct_row_buf.sv
// One-row sample buffer for the DCT row sequencer.
// N x DW register file, one synchronous write port and one asynchronous
// read port. Contents are deliberately not reset: a row is always fully
// rewritten before it is replayed.
// Ports:
//   clk   : rising-edge clock
//   we    : write enable
//   waddr : write index
//   wdata : write data
//   raddr : read index
//   rdata : read data (combinational from the storage registers)
module dct_row_buf
    import dct_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int DW = DW_DEF
)
(
    input  logic                 clk,
    input  logic                 we,
    input  logic [$clog2(N)-1:0] waddr,
    input  logic [DW-1:0]        wdata,
    input  logic [$clog2(N)-1:0] raddr,
    output logic [DW-1:0]        rdata
);

    logic [DW-1:0] mem_r [N];

    // Storage write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/dct_row_sequencer.sv
// Frame sequencer for the DCT add_up datapath.
// Collects one N-sample row from the sample stream, clears the datapath,
// replays the row one sample per clock, waits LAT cycles for the datapath
// results, captures them and offers them on the result stream.
// Ports:
//   clk    : rising-edge clock
//   rst    : asynchronous active-low reset
//   bus    : sample stream, datapath drive and result stream (master side)
//   busy   : high in every state except FILL
//   frames : completed result handshakes, modulo 256
// Every output is a flop; nothing combinational reaches an output from an input.
module dct_row_sequencer
    import dct_pkg::*;
#(
    parameter int N   = N_DEF,
    parameter int DW  = DW_DEF,
    parameter int OW  = OW_DEF,
    parameter int LAT = 2
)
(
    input  logic                clk,
    input  logic                rst,
    dct_row_sequencer_if.master bus,
    output logic                busy,
    output logic [7:0]          frames
);

    localparam int AW = $clog2(N);
    localparam int LW = (LAT > 1) ? $clog2(LAT) : 1;

    state_t          state_r;
    logic [AW-1:0]   wcnt_r;
    logic [AW-1:0]   rcnt_r;
    logic [LW-1:0]   lcnt_r;
    logic            s_ready_r;
    logic            dp_clr_r;
    logic            dp_en_r;
    logic [DW-1:0]   dp_in_r;
    logic            m_valid_r;
    logic [OW-1:0]   m_data0_r;
    logic [OW-1:0]   m_data1_r;
    logic [OW-1:0]   m_data2_r;
    logic [OW-1:0]   m_data3_r;
    logic            busy_r;
    logic [7:0]      frames_r;

    logic            we_s;
    logic [AW-1:0]   raddr_s;
    logic [DW-1:0]   rdata_s;

    // A sample is written only while FILL is offering s_ready.
    assign we_s = (state_r == FILL) & s_ready_r & bus.s_valid;

    // Read address runs one ahead of rcnt so dp_in_r can be loaded with the
    // next sample at the same edge rcnt advances; CLR preloads sample 0.
    always_comb begin
        if (state_r == ISSUE) begin
            raddr_s = rcnt_r + AW'(1);
        end else begin
            raddr_s = '0;
        end
    end

    dct_row_buf #(
        .N  (N),
        .DW (DW)
    ) u_buf (
        .clk   (clk),
        .we    (we_s),
        .waddr (wcnt_r),
        .wdata (bus.s_data),
        .raddr (raddr_s),
        .rdata (rdata_s)
    );

    // Sequencer FSM, counters and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= FILL;
            wcnt_r    <= '0;
            rcnt_r    <= '0;
            lcnt_r    <= '0;
            s_ready_r <= 1'b0;
            dp_clr_r  <= 1'b0;
            dp_en_r   <= 1'b0;
            dp_in_r   <= '0;
            m_valid_r <= 1'b0;
            m_data0_r <= '0;
            m_data1_r <= '0;
            m_data2_r <= '0;
            m_data3_r <= '0;
            busy_r    <= 1'b0;
            frames_r  <= 8'd0;
        end else begin
            case (state_r)
                FILL: begin
                    s_ready_r <= 1'b1;
                    busy_r    <= 1'b0;
                    dp_clr_r  <= 1'b0;
                    dp_en_r   <= 1'b0;
                    dp_in_r   <= '0;
                    if (we_s) begin
                        if (wcnt_r == AW'(N - 1)) begin
                            // Row complete: drop s_ready and pulse the clear.
                            wcnt_r    <= '0;
                            s_ready_r <= 1'b0;
                            dp_clr_r  <= 1'b1;
                            busy_r    <= 1'b1;
                            state_r   <= CLR;
                        end else begin
                            wcnt_r <= wcnt_r + AW'(1);
                        end
                    end
                end
                CLR: begin
                    dp_clr_r <= 1'b0;
                    dp_en_r  <= 1'b1;
                    dp_in_r  <= rdata_s;
                    rcnt_r   <= '0;
                    state_r  <= ISSUE;
                end
                ISSUE: begin
                    if (rcnt_r == AW'(N - 1)) begin
                        dp_en_r <= 1'b0;
                        dp_in_r <= '0;
                        rcnt_r  <= '0;
                        lcnt_r  <= '0;
                        state_r <= WAIT;
                    end else begin
                        rcnt_r  <= rcnt_r + AW'(1);
                        dp_in_r <= rdata_s;
                    end
                end
                WAIT: begin
                    if (lcnt_r == LW'(LAT - 1)) begin
                        // Datapath results are settled on this cycle.
                        m_data0_r <= bus.dp_o1;
                        m_data1_r <= bus.dp_o2;
                        m_data2_r <= bus.dp_o3;
                        m_data3_r <= bus.dp_o4;
                        m_valid_r <= 1'b1;
                        lcnt_r    <= '0;
                        state_r   <= OUT;
                    end else begin
                        lcnt_r <= lcnt_r + LW'(1);
                    end
                end
                OUT: begin
                    if (bus.m_ready) begin
                        m_valid_r <= 1'b0;
                        frames_r  <= frames_r + 8'd1;
                        s_ready_r <= 1'b1;
                        busy_r    <= 1'b0;
                        state_r   <= FILL;
                    end
                end
                default: begin
                    // Unreachable encoding: park safely in FILL.
                    state_r   <= FILL;
                    wcnt_r    <= '0;
                    rcnt_r    <= '0;
                    lcnt_r    <= '0;
                    s_ready_r <= 1'b0;
                    dp_clr_r  <= 1'b0;
                    dp_en_r   <= 1'b0;
                    dp_in_r   <= '0;
                    m_valid_r <= 1'b0;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.s_ready = s_ready_r;
    assign bus.dp_clr  = dp_clr_r;
    assign bus.dp_en   = dp_en_r;
    assign bus.dp_in   = dp_in_r;
    assign bus.m_valid = m_valid_r;
    assign bus.m_data0 = m_data0_r;
    assign bus.m_data1 = m_data1_r;
    assign bus.m_data2 = m_data2_r;
    assign bus.m_data3 = m_data3_r;
    assign busy        = busy_r;
    assign frames      = frames_r;

endmodule

// File: tb/tb_dct_row_sequencer.sv
// Scoreboard bench for dct_row_sequencer: a driver issues rows and pushes the
// expected datapath feed and result set; a negedge monitor tracks the expected
// timeline from the row-acceptance times and compares every cycle.
module tb_dct_row_sequencer;
    import dct_pkg::*;

    localparam int N      = 8;
    localparam int DW     = 15;
    localparam int OW     = 18;
    localparam int LAT    = 2;
    localparam int PERIOD = 2 * N + LAT + 2;

    typedef logic [DW-1:0] row_t [N];

    logic       clk = 1'b0;
    logic       rst;
    logic       busy;
    logic [7:0] frames;

    dct_row_sequencer_if #(.DW(DW), .OW(OW)) bus ();

    dct_row_sequencer #(.N(N), .DW(DW), .OW(OW), .LAT(LAT)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .busy   (busy),
        .frames (frames)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0]     exp_dp_q [$];
    logic [4*OW-1:0]   exp_res_q [$];

    function automatic logic [OW-1:0] sx(input logic [DW-1:0] v);
        return {{(OW-DW){v[DW-1]}}, v};
    endfunction

    // Reference result: o1 = row sum, o2 = sum of even positions,
    // o3 = xor of raw samples, o4 = last sample (o1 forced to 0x123 if fixed).
    function automatic logic [4*OW-1:0] ref_result(input row_t r, input bit fixed);
        logic [OW-1:0] s_all, s_even, x;
        s_all = '0; s_even = '0; x = '0;
        for (int i = 0; i < N; i++) begin
            s_all = s_all + sx(r[i]);
            if (i % 2 == 0) s_even = s_even + sx(r[i]);
            x = x ^ {{(OW-DW){1'b0}}, r[i]};
        end
        return {(fixed ? 18'h00123 : s_all), s_even, x, sx(r[N-1])};
    endfunction

    // Behavioural add_up stand-in: accumulates while dp_en, one extra register
    // stage so results settle exactly LAT=2 cycles after the last dp_en.
    bit            dp_fixed = 1'b0;
    logic [OW-1:0] a1, a2, a3, a4, d1, d2, d3, d4;
    int            a_idx;
    always @(posedge clk) begin
        if (bus.dp_clr) begin
            a1 <= '0; a2 <= '0; a3 <= '0; a4 <= '0; a_idx <= 0;
        end else if (bus.dp_en) begin
            a1 <= a1 + sx(bus.dp_in);
            if (a_idx % 2 == 0) a2 <= a2 + sx(bus.dp_in);
            a3 <= a3 ^ {{(OW-DW){1'b0}}, bus.dp_in};
            a4 <= sx(bus.dp_in);
            a_idx <= a_idx + 1;
        end
        d1 <= a1; d2 <= a2; d3 <= a3; d4 <= a4;
    end
    assign bus.dp_o1 = dp_fixed ? 18'h00123 : d1;
    assign bus.dp_o2 = d2;
    assign bus.dp_o3 = d3;
    assign bus.dp_o4 = d4;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic note_fail(input string nm);
        vectors++;
        miscompares++;
        $display("FAIL %s: got timeout expected event (cycle %0d)", nm, cyc);
    endtask

    // Expected-timeline state kept by the monitor.
    int         t8 = -1000;
    int         prev_t8 = -1;
    int         n_acc = 0;
    int         mv_hi = 0;
    bit         row_busy = 1'b0;
    bit         fresh = 1'b1;
    bit         period_chk = 1'b0;
    logic [7:0] exp_frames = 8'd0;
    logic       e_clr, e_en, e_mv, e_rdy;
    logic [DW-1:0] e_in;

    // Monitor: compare every output against the expected timeline, then
    // advance the timeline with this cycle's handshakes.
    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_s_ready", bus.s_ready, 1'b0);
            chk("rst_dp_en", bus.dp_en, 1'b0);
            chk("rst_dp_clr", bus.dp_clr, 1'b0);
            chk("rst_dp_in", bus.dp_in, '0);
            chk("rst_m_valid", bus.m_valid, 1'b0);
            chk("rst_busy", busy, 1'b0);
            chk("rst_frames", frames, 8'd0);
            chk("rst_m_data", {bus.m_data0, bus.m_data1, bus.m_data2, bus.m_data3}, '0);
            row_busy = 1'b0; fresh = 1'b1; n_acc = 0; exp_frames = 8'd0; mv_hi = 0;
            exp_dp_q.delete();
            exp_res_q.delete();
        end else begin
            e_rdy = !row_busy && !fresh;
            e_clr = row_busy && (cyc == t8 + 1);
            e_en  = row_busy && (cyc >= t8 + 2) && (cyc <= t8 + N + 1);
            e_mv  = row_busy && (cyc >= t8 + N + LAT + 2);
            e_in  = '0;
            if (e_en) begin
                if (exp_dp_q.size() == 0) note_fail("dp_expect_empty");
                else e_in = exp_dp_q.pop_front();
            end
            chk("s_ready", bus.s_ready, e_rdy);
            chk("dp_clr", bus.dp_clr, e_clr);
            chk("dp_en", bus.dp_en, e_en);
            chk("dp_in", bus.dp_in, e_in);
            chk("m_valid", bus.m_valid, e_mv);
            chk("busy", busy, row_busy);
            chk("frames", frames, exp_frames);
            if (e_mv) begin
                if (exp_res_q.size() == 0) note_fail("result_expect_empty");
                else chk("m_data", {bus.m_data0, bus.m_data1, bus.m_data2, bus.m_data3}, exp_res_q[0]);
                if (bus.m_ready) begin
                    if (exp_res_q.size() != 0) void'(exp_res_q.pop_front());
                    exp_frames = exp_frames + 8'd1;
                    row_busy = 1'b0;
                end
            end
            if (e_rdy && bus.s_valid) begin
                n_acc++;
                if (n_acc == N) begin
                    if (period_chk && prev_t8 >= 0) chk("row_period", cyc - prev_t8, PERIOD);
                    prev_t8 = cyc;
                    t8 = cyc;
                    row_busy = 1'b1;
                    n_acc = 0;
                end
            end
            fresh = 1'b0;
        end
        mv_hi = bus.m_valid ? mv_hi + 1 : 0;
    end

    // Sink: 0 = always ready, 1 = random, 2 = ready after 5 cycles of m_valid.
    int mr_mode = 0;
    initial begin
        bus.m_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (mr_mode)
                1:       bus.m_ready = ($urandom_range(0, 1) == 1);
                2:       bus.m_ready = (mv_hi >= 5);
                default: bus.m_ready = 1'b1;
            endcase
        end
    end

    // Source: gap_mode 0 = back-to-back, 1 = valid pattern 1,0,1,1,0, 2 = random.
    task automatic send_row(input row_t r, input int gap_mode, input bit fixed);
        int i, p, waitc;
        bit go;
        for (int k = 0; k < N; k++) exp_dp_q.push_back(r[k]);
        exp_res_q.push_back(ref_result(r, fixed));
        i = 0; p = 0; waitc = 0;
        while (i < N) begin
            @(posedge clk); #1;
            case (gap_mode)
                1:       go = (p % 5 != 1) && (p % 5 != 4);
                2:       go = ($urandom_range(0, 3) != 0);
                default: go = 1'b1;
            endcase
            p++;
            if (!go) begin
                bus.s_valid = 1'b0;
                bus.s_data  = DW'($urandom);
            end else begin
                bus.s_valid = 1'b1;
                bus.s_data  = r[i];
                @(negedge clk);
                if (bus.s_ready) begin
                    i++;
                    waitc = 0;
                end else begin
                    waitc++;
                    if (waitc > 100) begin
                        note_fail("s_ready_wait");
                        return;
                    end
                end
            end
        end
    endtask

    task automatic idle_in();
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((row_busy || exp_res_q.size() != 0) && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (k >= 300) note_fail("result_wait");
        @(negedge clk);
    endtask

    task automatic rand_row(output row_t r);
        for (int k = 0; k < N; k++) r[k] = DW'($urandom);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish expected finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        row_t r, r2;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Ramp 1.0 .. 8.0 with a fixed datapath answer.
        for (int k = 0; k < N; k++) r[k] = DW'(Q5_10_ONE * (k + 1));
        dp_fixed = 1'b1;
        send_row(r, 0, 1'b1);
        idle_in();
        wait_idle();
        dp_fixed = 1'b0;
        chk("frames_after_ramp", frames, 8'd1);

        // Output backpressure.
        mr_mode = 2;
        rand_row(r);
        send_row(r, 0, 1'b0);
        idle_in();
        wait_idle();
        mr_mode = 0;

        // Input gaps with negative samples.
        for (int k = 0; k < N; k++) r[k] = (k % 2 == 0) ? 15'h7C00 : 15'h4200;
        send_row(r, 1, 1'b0);
        idle_in();
        wait_idle();

        // Held s_valid across CLR/ISSUE/WAIT.
        rand_row(r);
        rand_row(r2);
        r2[0] = 15'h0C00;
        send_row(r, 0, 1'b0);
        send_row(r2, 0, 1'b0);
        idle_in();
        wait_idle();

        // Reset at the third ISSUE cycle, then a clean row.
        rand_row(r);
        send_row(r, 0, 1'b0);
        idle_in();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        rand_row(r);
        send_row(r, 0, 1'b0);
        idle_in();
        wait_idle();

        // 260 back-to-back rows: frames wraps, period fixed at PERIOD.
        prev_t8 = -1;
        period_chk = 1'b1;
        for (int n = 0; n < 260; n++) begin
            rand_row(r);
            send_row(r, 0, 1'b0);
        end
        idle_in();
        wait_idle();
        period_chk = 1'b0;

        // Random gaps and random backpressure.
        mr_mode = 1;
        for (int n = 0; n < 12; n++) begin
            rand_row(r);
            send_row(r, 2, 1'b0);
        end
        idle_in();
        wait_idle();
        mr_mode = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
